// File: rtl/debug_cmd_ctrl.sv
// UART debug command controller: pause/resume/step/breakpoint control and program upload.
// Optional inter-byte timeout enabled by defining DEBUG_TIMEOUT_EN.
module debug_cmd_ctrl #(
    parameter int PROG_ADDR_W    = 14,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    input  logic                   tx_ready,
    input  logic [31:0]            cpu_pc,
    input  logic                   cpu_instr_done,
    output logic                   cpu_pause,
    output logic                   cpu_rst_req,
    output logic                   prog_mode,
    output logic                   prog_we,
    output logic [PROG_ADDR_W-1:0] prog_addr,
    output logic [31:0]            prog_data
);

    typedef enum logic [2:0] {
        IDLE,
        RES_ARG,
        STEP,
        PROG_CNT,
        PROG_DATA
    } state_t;

    localparam logic [7:0] OP_SIGNAL = 8'h01;
    localparam logic [7:0] OP_OK     = 8'h02;

    if (TIMEOUT_CYCLES < 1 || PROG_ADDR_W < 1) begin : g_param_check
        $error("debug_cmd_ctrl: TIMEOUT_CYCLES and PROG_ADDR_W must be positive");
    end

    state_t                 state_q, state_d;
    logic                   pause_q, pause_d;
    logic                   bp_valid_q, bp_valid_d;
    logic                   bp_armed_q, bp_armed_d;
    logic [31:0]            bp_addr_q, bp_addr_d;
    logic [31:0]            arg_q, arg_d;
    logic [1:0]             byte_cnt_q, byte_cnt_d;
    logic                   sig_pend_q, sig_pend_d;
    logic                   ok_pend_q, ok_pend_d;
    logic                   tx_valid_q, tx_valid_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   frame_sig_q, frame_sig_d;
    logic [2:0]             frame_idx_q, frame_idx_d;
    logic [31:0]            frame_pc_q, frame_pc_d;
    logic                   prog_mode_q, prog_mode_d;
    logic                   prog_we_q, prog_we_d;
    logic [PROG_ADDR_W-1:0] prog_addr_q, prog_addr_d;
    logic [31:0]            prog_data_q, prog_data_d;
    logic [8:0]             words_left_q, words_left_d;
    logic                   cpu_rst_req_q, cpu_rst_req_d;

    logic        sig_req;
    logic        ok_req;
    logic        sig_start;
    logic        ok_start;
    logic        bp_hit;
    logic [31:0] word_next;

`ifdef DEBUG_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    assign word_next = {rx_data, arg_q[31:8]};
    assign bp_hit    = bp_armed_q && bp_valid_q && (cpu_pc == bp_addr_q);

    always_comb begin
        state_d       = state_q;
        pause_d       = pause_q;
        bp_valid_d    = bp_valid_q;
        bp_armed_d    = bp_armed_q;
        bp_addr_d     = bp_addr_q;
        arg_d         = arg_q;
        byte_cnt_d    = byte_cnt_q;
        prog_mode_d   = prog_mode_q;
        prog_we_d     = 1'b0;
        prog_addr_d   = prog_addr_q;
        prog_data_d   = prog_data_q;
        words_left_d  = words_left_q;
        cpu_rst_req_d = 1'b0;
        sig_req       = 1'b0;
        ok_req        = 1'b0;
`ifdef DEBUG_TIMEOUT_EN
        to_cnt_d      = '0;
`endif

        if (cpu_instr_done && bp_valid_q) begin
            bp_armed_d = 1'b1;
        end
        // A hit only counts while running; once paused the hold comes from pause_q.
        if (bp_hit && !pause_q) begin
            pause_d    = 1'b1;
            sig_req    = 1'b1;
            bp_armed_d = 1'b0;
        end
        if (prog_we_q) begin
            prog_addr_d = prog_addr_q + PROG_ADDR_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        8'h03: ok_req = 1'b1;
                        8'h04: begin
                            pause_d = 1'b1;
                            sig_req = 1'b1;
                        end
                        8'h05: begin
                            state_d    = RES_ARG;
                            byte_cnt_d = 2'd0;
                        end
                        8'h06: begin
                            if (pause_q) begin
                                state_d    = STEP;
                                pause_d    = 1'b0;
                                bp_armed_d = 1'b0;
                            end
                        end
                        8'h07: begin
                            pause_d     = 1'b1;
                            prog_mode_d = 1'b1;
                            state_d     = PROG_CNT;
                        end
                        default: ;
                    endcase
                end
            end
            RES_ARG: begin
                if (rx_valid) begin
                    arg_d      = word_next;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        bp_addr_d  = word_next;
                        bp_valid_d = (word_next != 32'd0);
                        bp_armed_d = 1'b0;
                        pause_d    = 1'b0;
                        state_d    = IDLE;
                    end
                end
            end
            STEP: begin
                if (cpu_instr_done) begin
                    pause_d = 1'b1;
                    sig_req = 1'b1;
                    state_d = IDLE;
                end
            end
            PROG_CNT: begin
                if (rx_valid) begin
                    words_left_d = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                    byte_cnt_d   = 2'd0;
                    prog_addr_d  = '0;
                    state_d      = PROG_DATA;
                end
            end
            PROG_DATA: begin
                // Finish one cycle after the final write so prog_mode still covers it.
                if (prog_we_q && words_left_q == 9'd0) begin
                    prog_mode_d   = 1'b0;
                    cpu_rst_req_d = 1'b1;
                    ok_req        = 1'b1;
                    state_d       = IDLE;
                end else if (rx_valid) begin
                    arg_d      = word_next;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        prog_data_d  = word_next;
                        prog_we_d    = 1'b1;
                        words_left_d = words_left_q - 9'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef DEBUG_TIMEOUT_EN
        if ((state_q == RES_ARG || state_q == PROG_CNT || state_q == PROG_DATA)
            && !rx_valid && !prog_we_q) begin
            if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                state_d     = IDLE;
                prog_mode_d = 1'b0;
                byte_cnt_d  = 2'd0;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
`endif
    end

    // Reply framer: one frame in flight, SIGNAL wins over OK at frame start.
    always_comb begin
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        frame_sig_d = frame_sig_q;
        frame_idx_d = frame_idx_q;
        frame_pc_d  = frame_pc_q;
        sig_start   = 1'b0;
        ok_start    = 1'b0;

        if (!tx_valid_q) begin
            if (sig_pend_q) begin
                sig_start   = 1'b1;
                tx_valid_d  = 1'b1;
                tx_data_d   = OP_SIGNAL;
                frame_sig_d = 1'b1;
                frame_idx_d = 3'd0;
                frame_pc_d  = cpu_pc;
            end else if (ok_pend_q) begin
                ok_start    = 1'b1;
                tx_valid_d  = 1'b1;
                tx_data_d   = OP_OK;
                frame_sig_d = 1'b0;
                frame_idx_d = 3'd0;
            end
        end else if (tx_ready) begin
            if (frame_sig_q && frame_idx_q != 3'd4) begin
                frame_idx_d = frame_idx_q + 3'd1;
                tx_data_d   = frame_pc_q[{frame_idx_q[1:0], 3'b000} +: 8];
            end else begin
                tx_valid_d = 1'b0;
            end
        end

        sig_pend_d = sig_req || (sig_pend_q && !sig_start);
        ok_pend_d  = ok_req  || (ok_pend_q  && !ok_start);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pause_q       <= 1'b0;
            bp_valid_q    <= 1'b0;
            bp_armed_q    <= 1'b0;
            bp_addr_q     <= '0;
            arg_q         <= '0;
            byte_cnt_q    <= '0;
            sig_pend_q    <= 1'b0;
            ok_pend_q     <= 1'b0;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= '0;
            frame_sig_q   <= 1'b0;
            frame_idx_q   <= '0;
            frame_pc_q    <= '0;
            prog_mode_q   <= 1'b0;
            prog_we_q     <= 1'b0;
            prog_addr_q   <= '0;
            prog_data_q   <= '0;
            words_left_q  <= '0;
            cpu_rst_req_q <= 1'b0;
`ifdef DEBUG_TIMEOUT_EN
            to_cnt_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            pause_q       <= pause_d;
            bp_valid_q    <= bp_valid_d;
            bp_armed_q    <= bp_armed_d;
            bp_addr_q     <= bp_addr_d;
            arg_q         <= arg_d;
            byte_cnt_q    <= byte_cnt_d;
            sig_pend_q    <= sig_pend_d;
            ok_pend_q     <= ok_pend_d;
            tx_valid_q    <= tx_valid_d;
            tx_data_q     <= tx_data_d;
            frame_sig_q   <= frame_sig_d;
            frame_idx_q   <= frame_idx_d;
            frame_pc_q    <= frame_pc_d;
            prog_mode_q   <= prog_mode_d;
            prog_we_q     <= prog_we_d;
            prog_addr_q   <= prog_addr_d;
            prog_data_q   <= prog_data_d;
            words_left_q  <= words_left_d;
            cpu_rst_req_q <= cpu_rst_req_d;
`ifdef DEBUG_TIMEOUT_EN
            to_cnt_q      <= to_cnt_d;
`endif
        end
    end

    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign cpu_pause   = pause_q || bp_hit;
    assign cpu_rst_req = cpu_rst_req_q;
    assign prog_mode   = prog_mode_q;
    assign prog_we     = prog_we_q;
    assign prog_addr   = prog_addr_q;
    assign prog_data   = prog_data_q;

endmodule
